// File: rtl/ddc_acc_pkg.sv
// Shared types and arithmetic helpers for the DDC accumulator/serializer.
// sat_add works on wide sign-extended operands so any lane width up to 127 bits can reuse it.
package ddc_acc_pkg;

  localparam int SAT_MAX_W = 128;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Returns {ovf, sum}; overflow is judged at width w, the low w bits of sum are the result.
  function automatic logic [SAT_MAX_W:0] sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                                 input logic signed [SAT_MAX_W-1:0] b,
                                                 input int w,
                                                 input bit sat_en);
    logic signed [SAT_MAX_W-1:0] sum;
    logic signed [SAT_MAX_W-1:0] max_v;
    logic ovf;
    sum = a + b;
    max_v = '0;
    max_v[w-1] = 1'b1;
    max_v = max_v - 1;
    ovf = sum[w] ^ sum[w-1];
    if (ovf && sat_en) begin
      sum = sum[w] ? ~max_v : max_v;
    end
    return {ovf, sum};
  endfunction

endpackage

// File: rtl/ddc_acc_serializer_lane.sv
// One signed accumulator: adds din on en, hands the frame value out on last and restarts from 0.
module acc_sat_lane import ddc_acc_pkg::*; #(
  parameter int DIN_W  = 32,
  parameter int ACC_W  = 48,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    last,
  input  logic signed [DIN_W-1:0] din,
  output logic signed [ACC_W-1:0] acc_q,
  output logic signed [ACC_W-1:0] frame_out,
  output logic                    ovf
);

  logic [SAT_MAX_W:0]         res;
  logic [SAT_MAX_W-1-ACC_W:0] unused_hi;

  always_comb begin
    res = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(din), ACC_W, SAT_EN);
  end

  assign frame_out = res[ACC_W-1:0];
  assign unused_hi = res[SAT_MAX_W-1:ACC_W];
  // A sample discarded by clr must not raise the overflow flag either.
  assign ovf = res[SAT_MAX_W] & en & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= last ? '0 : frame_out;
    end
  end

endmodule

// File: rtl/ddc_acc_serializer.sv
// Integrates N_CH complex DDC streams per frame and serialises each frame snapshot
// onto a single AXI-Stream master with channel tag and tlast.
module ddc_acc_serializer import ddc_acc_pkg::*; #(
  parameter int N_CH      = 4,
  parameter int DDC_WIDTH = 32,
  parameter int ACC_WIDTH = 48,
  parameter int LEN_WIDTH = 32,
  parameter bit SAT_EN    = 1'b1,
  localparam int CH_W     = ch_w(N_CH)
) (
  input  logic                        dev_clk,
  input  logic                        dev_rst,
  input  logic [N_CH*2*DDC_WIDTH-1:0] s_ddc_tdata,
  input  logic                        s_ddc_tvalid,
  input  logic [LEN_WIDTH-1:0]        acc_len,
  input  logic                        resync,
  output logic [2*ACC_WIDTH-1:0]      m_axis_tdata,
  output logic [CH_W-1:0]             m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [31:0]                 frame_cnt,
  output logic [15:0]                 drop_cnt,
  output logic                        ovf_flag,
  input  logic                        ovf_clear
);

  logic [LEN_WIDTH-1:0]   cnt;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   len_cur;
  logic                   sample_en;
  logic                   frame_last;
  ser_state_t             state;
  ser_state_t             state_next;
  logic [CH_W-1:0]        ch;
  logic [CH_W-1:0]        ch_next;
  logic [2*ACC_WIDTH-1:0] bank  [N_CH];
  logic [2*ACC_WIDTH-1:0] frame [N_CH];
  logic [2*N_CH-1:0]      lane_ovf;
  logic                   tlast_hs;
  logic                   bank_load;
  logic                   frame_drop;

  assign sample_en = s_ddc_tvalid & ~resync;

  // The length is taken from acc_len only on the first sample of a frame.
  always_comb begin
    len_cur = len_q;
    if (cnt == '0) begin
      len_cur = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
    end
  end

  assign frame_last = sample_en & (cnt == len_cur - LEN_WIDTH'(1));

  always_ff @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      cnt   <= '0;
      len_q <= '0;
    end else if (resync) begin
      cnt <= '0;
    end else if (s_ddc_tvalid) begin
      if (cnt == '0) begin
        len_q <= len_cur;
      end
      cnt <= frame_last ? '0 : cnt + LEN_WIDTH'(1);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic signed [ACC_WIDTH-1:0] frame_i;
    logic signed [ACC_WIDTH-1:0] frame_q;
    logic signed [ACC_WIDTH-1:0] unused_acc_i;
    logic signed [ACC_WIDTH-1:0] unused_acc_q;

    acc_sat_lane #(.DIN_W(DDC_WIDTH), .ACC_W(ACC_WIDTH), .SAT_EN(SAT_EN)) u_lane_i (
      .clk(dev_clk), .rst(dev_rst), .clr(resync), .en(s_ddc_tvalid), .last(frame_last),
      .din(s_ddc_tdata[c*2*DDC_WIDTH +: DDC_WIDTH]),
      .acc_q(unused_acc_i), .frame_out(frame_i), .ovf(lane_ovf[2*c])
    );

    acc_sat_lane #(.DIN_W(DDC_WIDTH), .ACC_W(ACC_WIDTH), .SAT_EN(SAT_EN)) u_lane_q (
      .clk(dev_clk), .rst(dev_rst), .clr(resync), .en(s_ddc_tvalid), .last(frame_last),
      .din(s_ddc_tdata[c*2*DDC_WIDTH+DDC_WIDTH +: DDC_WIDTH]),
      .acc_q(unused_acc_q), .frame_out(frame_q), .ovf(lane_ovf[2*c+1])
    );

    assign frame[c] = {frame_q, frame_i};
  end

  // A new frame is only taken when the bank is free or being freed this very cycle.
  assign tlast_hs   = (state == ST_SEND) & m_axis_tready & (ch == CH_W'(N_CH-1));
  assign bank_load  = frame_last & ((state == ST_IDLE) | tlast_hs);
  assign frame_drop = frame_last & ~bank_load;

  always_comb begin
    state_next = state;
    ch_next    = ch;
    if (bank_load) begin
      state_next = ST_SEND;
      ch_next    = '0;
    end else if (tlast_hs) begin
      state_next = ST_IDLE;
    end else if ((state == ST_SEND) && m_axis_tready) begin
      ch_next = ch + CH_W'(1);
    end
  end

  always_ff @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      state     <= ST_IDLE;
      ch        <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      ovf_flag  <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        bank[c] <= '0;
      end
    end else begin
      state <= state_next;
      ch    <= ch_next;
      if (bank_load) begin
        bank <= frame;
      end
      if (tlast_hs) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
      if (frame_drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (|lane_ovf) begin
        ovf_flag <= 1'b1;
      end else if (ovf_clear) begin
        ovf_flag <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = (state == ST_SEND);
  assign m_axis_tdata  = bank[ch];
  assign m_axis_tuser  = ch;
  assign m_axis_tlast  = m_axis_tvalid & (ch == CH_W'(N_CH-1));

endmodule

// File: tb/tb_ddc_acc_serializer.sv
// Bench for ddc_acc_serializer: a frame-level model scores the main instance every cycle,
// two tiny N_CH=1 8-bit instances pin saturating versus wrapping overflow.
`timescale 1ns/1ps
module tb_ddc_acc_serializer;

  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int AW   = 48;
  localparam int LW   = 32;
  localparam longint AMAX = (longint'(1) <<< (AW-1)) - 1;
  localparam longint AMIN = -AMAX - 1;

  logic              dev_clk = 1'b0;
  logic              dev_rst = 1'b1;
  logic [N_CH*2*DW-1:0] s_ddc_tdata;
  logic              s_ddc_tvalid = 1'b0;
  logic [LW-1:0]     acc_len = 4;
  logic              resync = 1'b0;
  logic [2*AW-1:0]   m_axis_tdata;
  logic [1:0]        m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic [31:0]       frame_cnt;
  logic [15:0]       drop_cnt;
  logic              ovf_flag;
  logic              ovf_clear = 1'b0;
  int                si [N_CH];
  int                sq [N_CH];

  logic [15:0] sm_data = '0;
  logic        sm_valid = 1'b0;
  logic        sm_clear = 1'b0;
  logic        sm_resync = 1'b0;
  logic        sm_ready = 1'b1;
  logic [LW-1:0] sm_len = 2;
  logic [15:0] sms_tdata, smw_tdata;
  logic [0:0]  sms_tuser, smw_tuser;
  logic        sms_tlast, smw_tlast, sms_tvalid, smw_tvalid, sms_ovf, smw_ovf;
  logic [31:0] sms_frames, smw_frames;
  logic [15:0] sms_drops, smw_drops;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 dev_clk = ~dev_clk;

  always_comb begin
    s_ddc_tdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      s_ddc_tdata[c*2*DW +: 2*DW] = {sq[c], si[c]};
    end
  end

  ddc_acc_serializer #(.N_CH(N_CH), .DDC_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW), .SAT_EN(1'b1)) dut (
    .dev_clk(dev_clk), .dev_rst(dev_rst), .s_ddc_tdata(s_ddc_tdata), .s_ddc_tvalid(s_ddc_tvalid),
    .acc_len(acc_len), .resync(resync), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .ovf_flag(ovf_flag), .ovf_clear(ovf_clear)
  );

  ddc_acc_serializer #(.N_CH(1), .DDC_WIDTH(8), .ACC_WIDTH(8), .LEN_WIDTH(LW), .SAT_EN(1'b1)) dut_sat (
    .dev_clk(dev_clk), .dev_rst(dev_rst), .s_ddc_tdata(sm_data), .s_ddc_tvalid(sm_valid),
    .acc_len(sm_len), .resync(sm_resync), .m_axis_tdata(sms_tdata), .m_axis_tuser(sms_tuser),
    .m_axis_tlast(sms_tlast), .m_axis_tvalid(sms_tvalid), .m_axis_tready(sm_ready),
    .frame_cnt(sms_frames), .drop_cnt(sms_drops), .ovf_flag(sms_ovf), .ovf_clear(sm_clear)
  );

  ddc_acc_serializer #(.N_CH(1), .DDC_WIDTH(8), .ACC_WIDTH(8), .LEN_WIDTH(LW), .SAT_EN(1'b0)) dut_wrap (
    .dev_clk(dev_clk), .dev_rst(dev_rst), .s_ddc_tdata(sm_data), .s_ddc_tvalid(sm_valid),
    .acc_len(sm_len), .resync(sm_resync), .m_axis_tdata(smw_tdata), .m_axis_tuser(smw_tuser),
    .m_axis_tlast(smw_tlast), .m_axis_tvalid(smw_tvalid), .m_axis_tready(sm_ready),
    .frame_cnt(smw_frames), .drop_cnt(smw_drops), .ovf_flag(smw_ovf), .ovf_clear(sm_clear)
  );

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input int base, input bit rs);
    s_ddc_tvalid = v;
    resync = rs;
    for (int c = 0; c < N_CH; c++) begin
      si[c] = base * (c + 1);
      sq[c] = -base * (c + 1);
    end
    @(posedge dev_clk);
    #2;
  endtask

  // Frame-level model: running sums per channel, a snapshot bank and a count of beats still owed.
  longint      mi [N_CH];
  longint      mq [N_CH];
  longint      bi [N_CH];
  longint      bq [N_CH];
  longint      m_cnt = 0;
  longint      m_len = 1;
  int          m_rem = 0;
  int unsigned m_frames = 0;
  int          m_drops = 0;
  bit          m_ovf = 1'b0;

  function automatic longint sat_acc(input longint a, input longint b, inout bit o);
    longint s;
    s = a + b;
    if (s > AMAX) begin o = 1'b1; return AMAX; end
    if (s < AMIN) begin o = 1'b1; return AMIN; end
    return s;
  endfunction

  always @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      for (int c = 0; c < N_CH; c++) begin
        mi[c] = 0; mq[c] = 0; bi[c] = 0; bq[c] = 0;
      end
      m_cnt = 0; m_rem = 0; m_frames = 0; m_drops = 0; m_ovf = 1'b0;
    end else begin
      bit any_ovf;
      bit hs;
      bit done;
      any_ovf = 1'b0;
      done = 1'b0;
      hs = (m_rem > 0) && m_axis_tready;
      if (resync) begin
        for (int c = 0; c < N_CH; c++) begin mi[c] = 0; mq[c] = 0; end
        m_cnt = 0;
      end else if (s_ddc_tvalid) begin
        if (m_cnt == 0) m_len = (acc_len == 0) ? 1 : longint'(acc_len);
        for (int c = 0; c < N_CH; c++) begin
          mi[c] = sat_acc(mi[c], longint'(si[c]), any_ovf);
          mq[c] = sat_acc(mq[c], longint'(sq[c]), any_ovf);
        end
        m_cnt++;
        if (m_cnt == m_len) begin done = 1'b1; m_cnt = 0; end
      end
      if (hs && m_rem == 1) m_frames++;
      if (done && (m_rem == 0 || (hs && m_rem == 1))) begin
        for (int c = 0; c < N_CH; c++) begin bi[c] = mi[c]; bq[c] = mq[c]; end
        m_rem = N_CH;
      end else begin
        if (done && m_drops < 65535) m_drops++;
        if (hs) m_rem--;
      end
      if (done) begin
        for (int c = 0; c < N_CH; c++) begin mi[c] = 0; mq[c] = 0; end
      end
      m_ovf = any_ovf ? 1'b1 : (ovf_clear ? 1'b0 : m_ovf);
    end
  end

  always @(posedge dev_clk) begin
    int k;
    #1;
    checkOutput("tvalid", 96'(m_axis_tvalid), 96'(m_rem > 0));
    if (m_rem > 0) begin
      k = N_CH - m_rem;
      checkOutput("tdata", m_axis_tdata, {48'(bq[k]), 48'(bi[k])});
      checkOutput("tuser", 96'(m_axis_tuser), 96'(k));
      checkOutput("tlast", 96'(m_axis_tlast), 96'(k == N_CH - 1));
    end
    checkOutput("frame_cnt", 96'(frame_cnt), 96'(m_frames));
    checkOutput("drop_cnt", 96'(drop_cnt), 96'(m_drops));
    checkOutput("ovf_flag", 96'(ovf_flag), 96'(m_ovf));
  end

  initial begin
    for (int c = 0; c < N_CH; c++) begin si[c] = 0; sq[c] = 0; end
    @(posedge dev_clk);
    #2;
    checkOutput("rst_tvalid", 96'(m_axis_tvalid), 96'(0));
    checkOutput("rst_tdata", m_axis_tdata, 96'(0));
    checkOutput("rst_sm_tlast", 96'(sms_tlast), 96'(0));
    @(posedge dev_clk);
    #2;
    dev_rst = 1'b0;

    // Overflow on 8-bit lanes: 100 + 100.
    sm_data = {8'd0, 8'd100};
    sm_valid = 1'b1;
    repeat (2) begin @(posedge dev_clk); #2; end
    sm_valid = 1'b0;
    checkOutput("sat_tvalid", 96'(sms_tvalid), 96'(1));
    checkOutput("sat_tdata", 96'(sms_tdata), 96'(16'h007F));
    checkOutput("sat_tlast", 96'(sms_tlast), 96'(1));
    checkOutput("sat_tuser", 96'(sms_tuser), 96'(0));
    checkOutput("sat_ovf", 96'(sms_ovf), 96'(1));
    checkOutput("wrap_tdata", 96'(smw_tdata), 96'(16'h00C8));
    checkOutput("wrap_tlast", 96'(smw_tlast), 96'(1));
    checkOutput("wrap_ovf", 96'(smw_ovf), 96'(1));
    sm_clear = 1'b1;
    @(posedge dev_clk); #2;
    sm_clear = 1'b0;
    checkOutput("sat_ovf_clr", 96'(sms_ovf), 96'(0));
    checkOutput("wrap_ovf_clr", 96'(smw_ovf), 96'(0));
    checkOutput("sat_frames", 96'(sms_frames), 96'(1));
    checkOutput("wrap_frames", 96'(smw_frames), 96'(1));
    checkOutput("sat_tvalid_idle", 96'(sms_tvalid), 96'(0));
    sm_valid = 1'b1;
    @(posedge dev_clk); #2;
    sm_clear = 1'b1;
    @(posedge dev_clk); #2;
    sm_valid = 1'b0;
    sm_clear = 1'b0;
    checkOutput("sat_ovf_vs_clr", 96'(sms_ovf), 96'(1));
    checkOutput("wrap_ovf_vs_clr", 96'(smw_ovf), 96'(1));
    checkOutput("sat_drops", 96'(sms_drops), 96'(0));
    checkOutput("wrap_drops", 96'(smw_drops), 96'(0));
    checkOutput("wrap_tuser", 96'(smw_tuser), 96'(0));
    checkOutput("wrap_tvalid", 96'(smw_tvalid), 96'(1));

    // Continuous valid, length 4.
    acc_len = 4;
    repeat (4) applyStimulus(1'b1, 1, 1'b0);
    checkOutput("t1_tvalid", 96'(m_axis_tvalid), 96'(1));
    checkOutput("t1_tuser", 96'(m_axis_tuser), 96'(0));
    checkOutput("t1_tdata", m_axis_tdata, {48'hFFFF_FFFF_FFFC, 48'h4});
    repeat (8) applyStimulus(1'b1, 1, 1'b0);
    repeat (6) applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t1_frames", 96'(frame_cnt), 96'(3));
    checkOutput("t1_drops", 96'(drop_cnt), 96'(0));

    // Backpressure: one frame held, three dropped.
    acc_len = 2;
    m_axis_tready = 1'b0;
    repeat (8) applyStimulus(1'b1, 1, 1'b0);
    repeat (3) applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t2_tvalid", 96'(m_axis_tvalid), 96'(1));
    checkOutput("t2_tuser", 96'(m_axis_tuser), 96'(0));
    checkOutput("t2_tdata", m_axis_tdata, {48'hFFFF_FFFF_FFFE, 48'h2});
    checkOutput("t2_drops", 96'(drop_cnt), 96'(3));
    m_axis_tready = 1'b1;
    repeat (6) applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t2_frames", 96'(frame_cnt), 96'(4));

    // resync mid-frame while a frame is in flight.
    acc_len = 4;
    repeat (4) applyStimulus(1'b1, 1, 1'b0);
    repeat (2) applyStimulus(1'b1, 5, 1'b0);
    applyStimulus(1'b1, 5, 1'b1);
    repeat (4) applyStimulus(1'b1, 2, 1'b0);
    checkOutput("t4_frames", 96'(frame_cnt), 96'(5));
    checkOutput("t4_tdata", m_axis_tdata, {48'hFFFF_FFFF_FFF8, 48'h8});
    repeat (6) applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t4_frames_end", 96'(frame_cnt), 96'(6));

    // acc_len = 0, then a length change in the middle of a frame.
    acc_len = 0;
    applyStimulus(1'b1, 3, 1'b0);
    checkOutput("t5_tdata", m_axis_tdata, {48'hFFFF_FFFF_FFFD, 48'h3});
    applyStimulus(1'b1, 3, 1'b0);
    repeat (5) applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t5_drops", 96'(drop_cnt), 96'(4));
    checkOutput("t5_frames", 96'(frame_cnt), 96'(7));
    acc_len = 4;
    repeat (2) applyStimulus(1'b1, 1, 1'b0);
    acc_len = 8;
    repeat (2) applyStimulus(1'b1, 1, 1'b0);
    checkOutput("t5_len_old", m_axis_tdata, {48'hFFFF_FFFF_FFFC, 48'h4});
    repeat (8) applyStimulus(1'b1, 1, 1'b0);
    checkOutput("t5_len_new", m_axis_tdata, {48'hFFFF_FFFF_FFF8, 48'h8});
    repeat (6) applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t5_frames_end", 96'(frame_cnt), 96'(9));

    // Back-to-back frames, then async reset in the middle of a frame.
    acc_len = N_CH;
    repeat (4) applyStimulus(1'b1, 1, 1'b0);
    repeat (8) begin
      applyStimulus(1'b1, 1, 1'b0);
      checkOutput("t6_b2b_tvalid", 96'(m_axis_tvalid), 96'(1));
    end
    repeat (2) applyStimulus(1'b1, 1, 1'b0);
    dev_rst = 1'b1;
    #1;
    checkOutput("t6_rst_tvalid", 96'(m_axis_tvalid), 96'(0));
    checkOutput("t6_rst_tdata", m_axis_tdata, 96'(0));
    checkOutput("t6_rst_tuser", 96'(m_axis_tuser), 96'(0));
    checkOutput("t6_rst_tlast", 96'(m_axis_tlast), 96'(0));
    checkOutput("t6_rst_frames", 96'(frame_cnt), 96'(0));
    checkOutput("t6_rst_drops", 96'(drop_cnt), 96'(0));
    checkOutput("t6_rst_ovf", 96'(sms_ovf), 96'(0));
    s_ddc_tvalid = 1'b0;
    @(posedge dev_clk);
    #2;
    dev_rst = 1'b0;
    repeat (4) applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t6_after_tvalid", 96'(m_axis_tvalid), 96'(0));
    checkOutput("t6_after_frames", 96'(frame_cnt), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
